affine_interp_filter_stream: RTL
================================

// Module: affine_interp_filter_stream
// PURPOSE
// Row-streaming separable sub-pel interpolation filter for affine MC/PROF. Accepts one
// reference row per beat, filters it horizontally, then vertically across an NTAPS-row
// window. Emits one row of BLK signed 16-bit intermediate samples per beat for PROF.
// Successor to the fixed 9x9-in/6x6-out filter: parametrised depth, taps and block size,
// valid/ready on both sides, zero-bubble back-to-back blocks, and a per-block sideband.
// PARAMETERS
// BIT_DEPTH  8   input sample width, legal 8..12
// NTAPS      6   filter taps, legal 4 or 6; IN_DIM = BLK+NTAPS-1 (local)
// BLK        6   output rows and columns per block (4x4 subblock + 1-pel PROF border)
// SB_W       32  sideband width (dMv/address bundle, forwarded untouched)
// PORTS
// clk       in   1                clock, all logic on posedge
// rst_n     in   1                async active-low reset
// in_valid  in   1                input row beat valid
// in_ready  out  1                input row accepted when in_valid&&in_ready
// in_row    in   IN_DIM*BIT_DEPTH reference row, pixel 0 in LSBs, unsigned
// frac_x    in   4                horizontal 1/16 phase; sampled on row 0 of a block
// frac_y    in   4                vertical 1/16 phase; sampled on row 0
// coef_x    in   NTAPS*8          signed horizontal taps, tap 0 in LSBs; sampled on row 0
// coef_y    in   NTAPS*8          signed vertical taps; sampled on row 0
// in_sb     in   SB_W             block sideband; sampled on row 0
// out_valid out  1                output row valid
// out_ready in   1                output row consumed when out_valid&&out_ready
// out_row   out  BLK*16           signed samples, column 0 in LSBs
// out_last  out  1                marks row BLK-1 of a block
// out_sb    out  SB_W             sideband of the block owning out_row
// BEHAVIOUR
// - Reset: out_valid=0, out_last=0, out_row=0, out_sb=0; row counter=0; stage valids=0.
//   Reset mid-block discards the partial block. First beat after release is row 0.
// - adv = !out_valid || out_ready. in_ready = adv, so in_ready=1 whenever out_valid=0.
//   When adv=0, every stage holds and out_row/out_last/out_sb stay stable.
// - Row counter counts accepted beats 0..IN_DIM-1 and wraps to 0 for the next block.
//   Row 0 captures frac/coef/sb. These params travel with each row through the stages,
//   so consecutive blocks need no idle cycle.
// - Stage H (1 cycle), for column j=0..BLK-1:
//   h[j] = frac_x==0 ? p[j+C]<<(14-BIT_DEPTH) : (sum_t coef_x[t]*p[j+t]) >>> (BIT_DEPTH-8),
//   with C = NTAPS/2-1. h is signed 16-bit.
// - Window: shift register holds the last NTAPS-1 H rows. Stage V fires only when the
//   H-stage row index >= NTAPS-1. It combines the window and the current H row (t=0 oldest):
//   v[j] = frac_y==0 ? h_row[C][j] : (sum_t coef_y[t]*h_row[t][j]) >>> 6.
//   The result is registered into out_row.
// - Latency: input row k (k>=NTAPS-1) accepted at cycle T gives output row k-(NTAPS-1),
//   valid at T+2 with no stall. Rows 0..NTAPS-2 produce no output.
// - Arithmetic: full-precision signed accumulators (>=24 bits). >>> is arithmetic shift,
//   no rounding offset. V result saturates to [-32768,32767]. H result cannot overflow
//   for legal taps (sum|c| <= 128).
// - Exactly BLK outputs per block, with out_last on the BLK-th. out_sb is constant
//   across a block and switches with the first row of the next block.
// - frac and coef are don't-care except on row 0. Taps are not checked to sum to 64.
// TESTING
// 1 BD=8,NTAPS=6, frac 0/0, all pixels 100 -> 6 rows all 6400; out_valid 2 cycles after
//   beat 5 and high 6 consecutive cycles; out_last only on 6th.
// 2 frac_x=8 coef_x={3,-11,40,40,-11,3}, frac_y=0, columns alternating 0/255
//   -> every sample 8160.
// 3 Same as 2 with out_ready low 5 cycles after 2nd output -> in_ready low, out_row stable,
//   final stream identical to golden, no loss or duplication.
// 4 Two blocks back-to-back (22 beats, in_valid always 1), different coefs, sb=0xA/0xB
//   -> 12 rows, out_sb flips at row 7, both blocks match C model.
// 5 rst_n low after 4 input beats -> out_valid 0 immediately. Full block after release
//   -> exactly 6 rows, no stale data.
// 6 BIT_DEPTH=10 all pixels 1023, frac 0/0 -> 16368. Tap sets driving V past
//   +/-32767 -> saturated.

Source files
------------

// File: rtl/affine_interp_filter_stream_if.sv
// Row-stream bundle for affine_interp_filter_stream.
//   in_*   : reference row beat plus the per-block phase, taps and sideband
//   out_*  : filtered row beat, last-row marker and the owning block's sideband
// The slave modport is the filter's view; the master modport is the source/sink view.
interface affine_interp_filter_stream_if #(
   parameter int BIT_DEPTH = 8,
   parameter int NTAPS     = 6,
   parameter int BLK       = 6,
   parameter int SB_W      = 32
);
   localparam int IN_DIM = BLK + NTAPS - 1;

   logic                        in_valid;
   logic                        in_ready;
   logic [IN_DIM*BIT_DEPTH-1:0] in_row;
   logic [3:0]                  frac_x;
   logic [3:0]                  frac_y;
   logic [NTAPS*8-1:0]          coef_x;
   logic [NTAPS*8-1:0]          coef_y;
   logic [SB_W-1:0]             in_sb;

   logic                        out_valid;
   logic                        out_ready;
   logic [BLK*16-1:0]           out_row;
   logic                        out_last;
   logic [SB_W-1:0]             out_sb;

   modport slave (
      input  in_valid, in_row, frac_x, frac_y, coef_x, coef_y, in_sb, out_ready,
      output in_ready, out_valid, out_row, out_last, out_sb
   );

   modport master (
      output in_valid, in_row, frac_x, frac_y, coef_x, coef_y, in_sb, out_ready,
      input  in_ready, out_valid, out_row, out_last, out_sb
   );
endinterface

// File: rtl/affine_interp_filter_stream.sv
// Separable sub-pel interpolation filter for affine MC / PROF, one row per beat.
// Each block is IN_DIM = BLK+NTAPS-1 reference rows; the block produces BLK rows of
// BLK signed 16-bit samples. Pipeline: H filter register -> V filter register (out_*).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   s          : slave side of affine_interp_filter_stream_if (row in, row out)
module affine_interp_filter_stream #(
   parameter int BIT_DEPTH = 8,
   parameter int NTAPS     = 6,
   parameter int BLK       = 6,
   parameter int SB_W      = 32
) (
   input logic                          clk,
   input logic                          rst_n,
   affine_interp_filter_stream_if.slave s
);
   localparam int IN_DIM = BLK + NTAPS - 1;
   localparam int CTR    = NTAPS / 2 - 1;
   localparam int CW     = $clog2(IN_DIM);
   localparam int RW     = BLK * 16;
   localparam int SH_F0  = 14 - BIT_DEPTH;
   localparam int SH_H   = BIT_DEPTH - 8;

   localparam logic [CW-1:0]     LAST_ROW = CW'(IN_DIM - 1);
   localparam logic [CW-1:0]     V_START  = CW'(NTAPS - 1);
   localparam logic signed [31:0] SAT_MAX = 32'sd32767;
   localparam logic signed [31:0] SAT_MIN = -32'sd32768;

   logic adv;
   logic fire_in;
   logic row0;
   logic v_fire;

   // per-block parameters captured on row 0
   logic [3:0]         bfx_q, bfx_d, bfy_q, bfy_d;
   logic [NTAPS*8-1:0] bcx_q, bcx_d, bcy_q, bcy_d;
   logic [SB_W-1:0]    bsb_q, bsb_d;

   // parameters in force for the beat presented now
   logic [3:0]         eff_fx, eff_fy;
   logic [NTAPS*8-1:0] eff_cx, eff_cy;
   logic [SB_W-1:0]    eff_sb;

   logic [CW-1:0] cnt_q, cnt_d;

   // H stage: the row plus the vertical params and sideband it carries
   logic               h_valid_q, h_valid_d;
   logic [CW-1:0]      h_idx_q, h_idx_d;
   logic [RW-1:0]      h_row_q, h_row_d;
   logic [3:0]         h_fy_q, h_fy_d;
   logic [NTAPS*8-1:0] h_cy_q, h_cy_d;
   logic [SB_W-1:0]    h_sb_q, h_sb_d;

   // window of the previous NTAPS-1 H rows, index 0 oldest
   logic [NTAPS-2:0][RW-1:0] win_q, win_d;
   logic [NTAPS-1:0][RW-1:0] hwin;

   logic            out_valid_q, out_valid_d;
   logic [RW-1:0]   out_row_q, out_row_d;
   logic            out_last_q, out_last_d;
   logic [SB_W-1:0] out_sb_q, out_sb_d;

   logic [RW-1:0]       h_comb;
   logic signed [31:0]  h_acc, c32, p32;
   logic [RW-1:0]       v_comb;
   logic signed [31:0]  v_acc, v_sh, cv32, hv32;

   assign s.in_ready  = adv;
   assign s.out_valid = out_valid_q;
   assign s.out_row   = out_row_q;
   assign s.out_last  = out_last_q;
   assign s.out_sb    = out_sb_q;

   always_comb begin
      adv     = !out_valid_q || s.out_ready;
      fire_in = s.in_valid && adv;
      row0    = (cnt_q == '0);
      eff_fx  = row0 ? s.frac_x : bfx_q;
      eff_fy  = row0 ? s.frac_y : bfy_q;
      eff_cx  = row0 ? s.coef_x : bcx_q;
      eff_cy  = row0 ? s.coef_y : bcy_q;
      eff_sb  = row0 ? s.in_sb  : bsb_q;
      v_fire  = h_valid_q && (h_idx_q >= V_START);
      // current H row sits above the window as the newest tap
      hwin    = {h_row_q, win_q};
   end

   // horizontal filter on the incoming row
   always_comb begin
      h_comb = '0;
      h_acc  = '0;
      c32    = '0;
      p32    = '0;
      for (int j = 0; j < BLK; j++) begin
         h_acc = '0;
         for (int t = 0; t < NTAPS; t++) begin
            c32   = {{24{eff_cx[t*8+7]}}, eff_cx[t*8 +: 8]};
            p32   = {{(32-BIT_DEPTH){1'b0}}, s.in_row[(j+t)*BIT_DEPTH +: BIT_DEPTH]};
            h_acc = h_acc + c32 * p32;
         end
         p32 = {{(32-BIT_DEPTH){1'b0}}, s.in_row[(j+CTR)*BIT_DEPTH +: BIT_DEPTH]};
         if (eff_fx == 4'd0) h_comb[j*16 +: 16] = 16'(p32 <<< SH_F0);
         else                h_comb[j*16 +: 16] = 16'(h_acc >>> SH_H);
      end
   end

   // vertical filter across window + current H row, saturated to 16 bits
   always_comb begin
      v_comb = '0;
      v_acc  = '0;
      v_sh   = '0;
      cv32   = '0;
      hv32   = '0;
      for (int j = 0; j < BLK; j++) begin
         v_acc = '0;
         for (int t = 0; t < NTAPS; t++) begin
            cv32  = {{24{h_cy_q[t*8+7]}}, h_cy_q[t*8 +: 8]};
            hv32  = {{16{hwin[t][j*16+15]}}, hwin[t][j*16 +: 16]};
            v_acc = v_acc + cv32 * hv32;
         end
         v_sh = v_acc >>> 6;
         if (h_fy_q == 4'd0)        v_comb[j*16 +: 16] = hwin[CTR][j*16 +: 16];
         else if (v_sh > SAT_MAX)   v_comb[j*16 +: 16] = 16'h7fff;
         else if (v_sh < SAT_MIN)   v_comb[j*16 +: 16] = 16'h8000;
         else                       v_comb[j*16 +: 16] = 16'(v_sh);
      end
   end

   always_comb begin
      bfx_d       = bfx_q;
      bfy_d       = bfy_q;
      bcx_d       = bcx_q;
      bcy_d       = bcy_q;
      bsb_d       = bsb_q;
      cnt_d       = cnt_q;
      h_valid_d   = h_valid_q;
      h_idx_d     = h_idx_q;
      h_row_d     = h_row_q;
      h_fy_d      = h_fy_q;
      h_cy_d      = h_cy_q;
      h_sb_d      = h_sb_q;
      win_d       = win_q;
      out_valid_d = out_valid_q;
      out_row_d   = out_row_q;
      out_last_d  = out_last_q;
      out_sb_d    = out_sb_q;

      if (fire_in) begin
         cnt_d = (cnt_q == LAST_ROW) ? '0 : cnt_q + 1'b1;
         if (row0) begin
            bfx_d = s.frac_x;
            bfy_d = s.frac_y;
            bcx_d = s.coef_x;
            bcy_d = s.coef_y;
            bsb_d = s.in_sb;
         end
      end

      // a stalled output freezes every stage
      if (adv) begin
         h_valid_d = fire_in;
         if (fire_in) begin
            h_idx_d = cnt_q;
            h_row_d = h_comb;
            h_fy_d  = eff_fy;
            h_cy_d  = eff_cy;
            h_sb_d  = eff_sb;
         end
         if (h_valid_q) win_d = hwin[NTAPS-1:1];
         out_valid_d = v_fire;
         out_last_d  = v_fire && (h_idx_q == LAST_ROW);
         if (v_fire) begin
            out_row_d = v_comb;
            out_sb_d  = h_sb_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bfx_q       <= '0;
         bfy_q       <= '0;
         bcx_q       <= '0;
         bcy_q       <= '0;
         bsb_q       <= '0;
         cnt_q       <= '0;
         h_valid_q   <= 1'b0;
         h_idx_q     <= '0;
         h_row_q     <= '0;
         h_fy_q      <= '0;
         h_cy_q      <= '0;
         h_sb_q      <= '0;
         win_q       <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_last_q  <= 1'b0;
         out_sb_q    <= '0;
      end else begin
         bfx_q       <= bfx_d;
         bfy_q       <= bfy_d;
         bcx_q       <= bcx_d;
         bcy_q       <= bcy_d;
         bsb_q       <= bsb_d;
         cnt_q       <= cnt_d;
         h_valid_q   <= h_valid_d;
         h_idx_q     <= h_idx_d;
         h_row_q     <= h_row_d;
         h_fy_q      <= h_fy_d;
         h_cy_q      <= h_cy_d;
         h_sb_q      <= h_sb_d;
         win_q       <= win_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         out_last_q  <= out_last_d;
         out_sb_q    <= out_sb_d;
      end
   end
endmodule
